multicycle_adder: RTL and testbench

//  Parametrised N-bit adder/subtractor built from CHUNK-bit full-adder slices.
//  - Computes WIDTH/CHUNK slices over successive cycles, LSB slice first.
//  - The carry is registered between slices.
//  - Valid/ready on input and output; next generation of the single-bit full adder.
//  - Sits between operand producers and the arithmetic result bus.

---
 rtl/multicycle_adder_pkg.sv | 22 ++
 rtl/adder_chunk.sv | 27 ++
 rtl/multicycle_adder.sv | 138 +++++++++++++
 tb/tb_multicycle_adder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multicycle adder/subtractor.
//   state_t    : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is illegal and
//                is decoded as IDLE by the FSM)
//   calc_nch() : number of CHUNK-bit slices, which is also the compute latency
//   calc_cw()  : slice counter width, $clog2(NCH) with a minimum of 1
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_cw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple of full-adder cells.
//   x, y : slice operands
//   ci   : carry into the slice LSB
//   s    : slice sum
//   co   : carry out of the slice MSB
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit adder/subtractor that resolves CHUNK bits per cycle, LSB slice
// first, through a single time-multiplexed adder_chunk with a registered carry.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : command handshake (in_ready high only in IDLE)
//   a, b, cin, sub       : operands, carry/borrow in, 0=add 1=subtract
//   out_valid/out_ready  : result handshake, result held until accepted
//   sum, carry, ovf      : result, raw MSB carry-out, signed overflow
//
// state | meaning
// IDLE  | waiting for a command, in_ready=1
// RUN   | one slice per cycle, slice index k counts 0..NCH-1
// DONE  | result presented with out_valid=1 until out_ready
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NCH = calc_nch(WIDTH, CHUNK);
  localparam int CW  = calc_cw(NCH);
  localparam logic [CW-1:0] K_LAST = CW'(NCH - 1);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             carry_q;
  logic             ovf_q;
  logic             accept;

  logic [CHUNK-1:0] x;
  logic [CHUNK-1:0] y;
  logic [CHUNK-1:0] s;
  logic             co;

  // Slice mux: constant part-selects keyed on k keep the select lint-clean.
  always_comb begin
    x = '0;
    y = '0;
    for (int i = 0; i < NCH; i++) begin
      if (k == CW'(i)) begin
        x = a_q[i*CHUNK +: CHUNK];
        y = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (x),
    .y  (y),
    .ci (c_q),
    .s  (s),
    .co (co)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (k == K_LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: begin
        // unused encoding behaves exactly like IDLE
        in_ready = 1'b1;
        state_nx = in_valid ? RUN : IDLE;
      end
    endcase
    accept = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        // subtraction is a + ~b + ~cin, so borrow-in becomes an inverted carry
        a_q <= a;
        b_q <= sub ? ~b : b;
        c_q <= sub ? ~cin : cin;
        k   <= '0;
      end else if (state == RUN) begin
        for (int i = 0; i < NCH; i++) begin
          if (k == CW'(i)) sum_q[i*CHUNK +: CHUNK] <= s;
        end
        c_q <= co;
        if (k == K_LAST) begin
          carry_q <= co;
          // s[CHUNK-1] is the final sum MSB on the last slice
          ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[CHUNK-1] != a_q[WIDTH-1]);
          k       <= '0;
        end else begin
          k <= k + CW'(1);
        end
      end
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
module tb_multicycle_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16-bit / 4-bit-chunk instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, carry, ovf;
  logic [15:0] a, b, sum;

  // 4-bit / 1-bit-chunk instance for the exhaustive sweep
  logic        sm_in_valid, sm_in_ready, sm_cin, sm_sub, sm_out_valid, sm_out_ready;
  logic        sm_carry, sm_ovf;
  logic [3:0]  sm_a, sm_b, sm_sum;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .ovf(ovf)
  );

  multicycle_adder #(.WIDTH(4), .CHUNK(1)) dut_sm (
    .clk(clk), .rst_n(rst_n), .in_valid(sm_in_valid), .in_ready(sm_in_ready),
    .a(sm_a), .b(sm_b), .cin(sm_cin), .sub(sm_sub), .out_valid(sm_out_valid),
    .out_ready(sm_out_ready), .sum(sm_sum), .carry(sm_carry), .ovf(sm_ovf)
  );

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  exp_t       q[$];
  logic [5:0] sq[$];   // {carry, ovf, sum[3:0]}

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard pop for the 16-bit instance: a result is consumed at the
  // next rising edge whenever out_valid && out_ready here
  always @(negedge clk) begin : mon_big
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else begin
        e = q.pop_front();
        check("sum",   32'(sum),   32'(e.sum));
        check("carry", 32'(carry), 32'(e.carry));
        check("ovf",   32'(ovf),   32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin : mon_small
    logic [5:0] e;
    if (rst_n && sm_out_valid && sm_out_ready) begin
      if (sq.size() == 0) check("sm_spurious_out", 32'(sm_out_valid), 32'd0);
      else begin
        e = sq.pop_front();
        check("sm_result", 32'({sm_carry, sm_ovf, sm_sum}), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int g = 0;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    check("idle_wait", 32'(in_ready), 32'd1);
  endtask

  // drives one command, pushes its expected result, checks the latency
  task automatic run_big(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcin, input logic tsub,
                         input logic [15:0] es, input logic ec, input logic eo);
    int cyc = 0;
    wait_idle();
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    q.push_back('{sum: es, carry: ec, ovf: eo});
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd4);
  endtask

  initial begin : stim
    logic [9:0]  v;
    logic [3:0]  beff;
    logic        c0;
    logic [4:0]  full;
    logic        eo;
    int          cyc;
    int          seen;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sm_in_valid = 1'b0; sm_a = '0; sm_b = '0; sm_cin = 1'b0; sm_sub = 1'b0; sm_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'h0);
    check("rst_carry",     32'(carry),     32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_big("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_big("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_big("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_big("add_cin",  16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    run_big("sub_5_7",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_big("sub_8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_big("sub_9_3b", 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);

    // backpressure: result held, new command ignored while DONE
    wait_idle();
    out_ready = 1'b0;
    run_big("bp", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_sum",       32'(sum),       32'h5555);
      check("bp_carry",     32'(carry),     32'd0);
      check("bp_ovf",       32'(ovf),       32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("bp_cmd_not_taken", 32'(seen), 32'd0);

    // reset on the second RUN cycle aborts the operation
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_running", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum",       32'(sum),       32'h0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    // exhaustive sweep on the 4-bit, 1-bit-chunk instance
    for (int i = 0; i < 1024; i++) begin
      v    = 10'(i);
      beff = v[9] ? ~v[7:4] : v[7:4];
      c0   = v[9] ? ~v[8] : v[8];
      full = {1'b0, v[3:0]} + {1'b0, beff} + {4'b0, c0};
      eo   = (v[3] == beff[3]) && (full[3] != v[3]);
      cyc  = 0;
      while (!sm_in_ready && cyc < 20) begin
        @(posedge clk); #1; cyc++;
      end
      sm_a = v[3:0]; sm_b = v[7:4]; sm_cin = v[8]; sm_sub = v[9]; sm_in_valid = 1'b1;
      sq.push_back({full[4], eo, full[3:0]});
      @(posedge clk); #1;
      sm_in_valid = 1'b0;
      cyc = 0;
      while (!sm_out_valid && cyc < 20) begin
        @(posedge clk); #1; cyc++;
      end
      check("sm_latency", 32'(cyc), 32'd4);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("big_queue_empty",   32'(q.size()),  32'd0);
    check("small_queue_empty", 32'(sq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
